// File: rtl/button_event.sv
// -----------------------------------------------------------------------------
// button_event
//   Turns a clean, clk-synchronous button level (from the debouncer) into
//   single-cycle event pulses for front-panel control logic, and keeps a
//   wrapping count of registered presses.
//
// Parameters
//   HOLD_CYCLES   : cycles the button must stay high after the press is
//                   registered before hold_pulse fires (2..65535)
//   REPEAT_CYCLES : spacing of repeat_pulse events during a long press
//                   (2..65535)
//   REPEAT_EN     : 1 enables auto-repeat, 0 suppresses repeat_pulse
//
// Ports
//   clk           : system clock, all logic on posedge
//   rst           : asynchronous, active-high reset
//   btn           : debounced button level, synchronous to clk
//   press_pulse   : one-cycle pulse on a registered press
//   release_pulse : one-cycle pulse on release
//   hold_pulse    : one-cycle pulse when a press reaches HOLD_CYCLES
//   repeat_pulse  : one-cycle pulse every REPEAT_CYCLES while long-pressed
//   held          : high while the button is considered down
//   press_count   : number of registered presses, wraps 255 -> 0
// -----------------------------------------------------------------------------
module button_event #(
  parameter logic [15:0] HOLD_CYCLES   = 16'd2000,
  parameter logic [15:0] REPEAT_CYCLES = 16'd500,
  parameter logic        REPEAT_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       hold_pulse,
  output logic       repeat_pulse,
  output logic       held,
  output logic [7:0] press_count
);

  // ARM blocks presses until the button has been seen low, so a button that
  // is already down when reset is released never counts as a press.
  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_IDLE = 2'd1,
    ST_DOWN = 2'd2,
    ST_LONG = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        press_q, press_d;
  logic        release_q, release_d;
  logic        hold_q, hold_d;
  logic        repeat_q, repeat_d;
  logic        held_q, held_d;
  logic [7:0]  count_q, count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_ARM;
      cnt_q     <= 16'd0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
      count_q   <= count_d;
    end
  end

  // Pulses default low every cycle, which keeps them exactly one cycle wide.
  // Within DOWN/LONG the release branch is tested first so a release on the
  // expiry edge suppresses hold/repeat.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    hold_d    = 1'b0;
    repeat_d  = 1'b0;
    held_d    = held_q;
    count_d   = count_q;

    case (state_q)
      ST_ARM: begin
        held_d = 1'b0;
        cnt_d  = 16'd0;
        if (!btn) begin
          state_d = ST_IDLE;
        end
      end

      ST_IDLE: begin
        if (btn) begin
          state_d = ST_DOWN;
          cnt_d   = 16'd0;
          press_d = 1'b1;
          held_d  = 1'b1;
          count_d = count_q + 8'd1;
        end
      end

      ST_DOWN: begin
        if (!btn) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          held_d    = 1'b0;
          cnt_d     = 16'd0;
        end else if (cnt_q == HOLD_CYCLES - 16'd1) begin
          state_d = ST_LONG;
          hold_d  = 1'b1;
          cnt_d   = 16'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      ST_LONG: begin
        if (!btn) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          held_d    = 1'b0;
          cnt_d     = 16'd0;
        end else if (REPEAT_EN && (cnt_q == REPEAT_CYCLES - 16'd1)) begin
          repeat_d = 1'b1;
          cnt_d    = 16'd0;
        end else if (REPEAT_EN) begin
          cnt_d = cnt_q + 16'd1;
        end else begin
          cnt_d = 16'd0;
        end
      end

      default: begin
        state_d = ST_ARM;
        held_d  = 1'b0;
        cnt_d   = 16'd0;
      end
    endcase
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign hold_pulse    = hold_q;
  assign repeat_pulse  = repeat_q;
  assign held          = held_q;
  assign press_count   = count_q;

endmodule

// File: tb/tb_button_event.sv
// -----------------------------------------------------------------------------
// tb_button_event
//   Directed bench for button_event. Two instances with HOLD=8, REPEAT=4:
//   dut_a with auto-repeat, dut_b without. Every press pushes its expected
//   pulse events (instance, cycle, pulse vector) onto a queue; a negedge
//   monitor pops and compares whenever an instance raises any pulse.
// -----------------------------------------------------------------------------
module tb_button_event;

  localparam int HOLD = 8;
  localparam int REP  = 4;

  // pulse vector encoding {press, release, hold, repeat}
  localparam int PV_PRESS   = 8;
  localparam int PV_RELEASE = 4;
  localparam int PV_HOLD    = 2;
  localparam int PV_REPEAT  = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_a, btn_b;
  logic       press_a, release_a, hold_a, repeat_a, held_a;
  logic       press_b, release_b, hold_b, repeat_b, held_b;
  logic [7:0] count_a, count_b;

  typedef struct {
    int dut;
    int cyc;
    int pv;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  total = 0;
  int  passed = 0;
  int  fails = 0;
  int  count_model[2];

  button_event #(.HOLD_CYCLES(16'd8), .REPEAT_CYCLES(16'd4), .REPEAT_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .btn(btn_a),
    .press_pulse(press_a), .release_pulse(release_a), .hold_pulse(hold_a),
    .repeat_pulse(repeat_a), .held(held_a), .press_count(count_a)
  );

  button_event #(.HOLD_CYCLES(16'd8), .REPEAT_CYCLES(16'd4), .REPEAT_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .btn(btn_b),
    .press_pulse(press_b), .release_pulse(release_b), .hold_pulse(hold_b),
    .repeat_pulse(repeat_b), .held(held_b), .press_count(count_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int pv_of(input int d);
    if (d == 0) return {28'd0, press_a, release_a, hold_a, repeat_a};
    return {28'd0, press_b, release_b, hold_b, repeat_b};
  endfunction

  function automatic int held_of(input int d);
    return (d == 0) ? int'(held_a) : int'(held_b);
  endfunction

  function automatic int count_of(input int d);
    return (d == 0) ? int'(count_a) : int'(count_b);
  endfunction

  task automatic push(input int d, input int c, input int pv);
    ev_t e;
    e.dut = d;
    e.cyc = c;
    e.pv  = pv;
    q.push_back(e);
  endtask

  task automatic set_btn(input int d, input logic v);
    if (d == 0) btn_a = v;
    else        btn_b = v;
  endtask

  // Scoreboard consumer: any pulse activity must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        int pv;
        pv = pv_of(d);
        if (pv != 0) begin
          if (q.size() == 0) begin
            chk("unexpected_pulse", pv, 0);
          end else begin
            ev_t e;
            e = q.pop_front();
            chk("event_dut", d, e.dut);
            chk("event_cycle", cyc, e.cyc);
            chk("event_pulses", pv, e.pv);
          end
        end
      end
    end
  end

  // Called right after a negedge. btn high for len sampled edges, then low.
  task automatic do_press(input int d, input int len, input bit rep_en);
    int n, p, r;
    n = cyc;
    p = n + 1;          // press visible one cycle after the first high sample
    r = p + len;        // release visible one cycle after the first low sample
    push(d, p, PV_PRESS);
    if (p + HOLD < r) begin
      push(d, p + HOLD, PV_HOLD);
      if (rep_en) begin
        for (int t = p + HOLD + REP; t < r; t += REP) push(d, t, PV_REPEAT);
      end
    end
    push(d, r, PV_RELEASE);
    count_model[d] = (count_model[d] + 1) % 256;
    set_btn(d, 1'b1);
    @(negedge clk);
    chk("held_at_press", held_of(d), 1);
    repeat (len - 1) @(negedge clk);
    chk("held_before_release", held_of(d), 1);
    set_btn(d, 1'b0);
    @(negedge clk);
    chk("held_after_release", held_of(d), 0);
    chk("press_count", count_of(d), count_model[d]);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    chk("rst_pulses_a", pv_of(0), 0);
    chk("rst_held_a", held_of(0), 0);
    chk("rst_count_a", count_of(0), 0);
    chk("rst_count_b", count_of(1), 0);
    count_model[0] = 0;
    count_model[1] = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    btn_a = 1'b0;
    btn_b = 1'b0;
    count_model[0] = 0;
    count_model[1] = 0;
    repeat (3) @(negedge clk);
    chk("reset_pulses_a", pv_of(0), 0);
    chk("reset_pulses_b", pv_of(1), 0);
    chk("reset_held_a", held_of(0), 0);
    chk("reset_count_a", count_of(0), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Reset mid-press: no release, and a button held through reset is ignored.
    $display("txn: reset mid-press");
    push(0, cyc + 1, PV_PRESS);
    btn_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("midpress_held", held_of(0), 1);
    chk("midpress_count", count_of(0), 1);
    pulse_reset();
    repeat (6) @(negedge clk);
    chk("armed_held", held_of(0), 0);
    chk("armed_count", count_of(0), 0);
    btn_a = 1'b0;
    repeat (2) @(negedge clk);

    $display("txn: short press len=5");
    do_press(0, 5, 1'b1);
    $display("txn: long press with repeat len=25");
    do_press(0, 25, 1'b1);
    $display("txn: release on hold expiry edge len=%0d", HOLD);
    do_press(0, HOLD, 1'b1);
    $display("txn: one past expiry len=%0d", HOLD + 1);
    do_press(0, HOLD + 1, 1'b1);
    $display("txn: repeat disabled len=40");
    do_press(1, 40, 1'b0);
    $display("txn: one-cycle glitch");
    do_press(0, 1, 1'b1);

    $display("txn: 257 short presses for wrap");
    pulse_reset();
    repeat (2) @(negedge clk);
    for (int i = 0; i < 257; i++) begin
      do_press(0, 1, 1'b1);
      if (i == 254) chk("count_255", count_of(0), 255);
    end
    chk("count_wrapped", count_of(0), 1);

    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/button_event.md
Name: button_event

Overview:
- Sits directly downstream of the push-button debouncer.
- Turns its clean, clk-synchronous level into single-cycle event pulses: press, release, long-press (hold) and auto-repeat.
- Also keeps a wrapping press counter.
- Feeds CPU front-panel control logic (single-step, run/halt, address increment).

Parameters:
- HOLD_CYCLES, 16'd2000: cycles btn must stay high after the press is registered before hold_pulse fires; legal range 2..65535.
- REPEAT_CYCLES, 16'd500: interval in cycles between repeat_pulse events while in long-press; legal range 2..65535.
- REPEAT_EN, 1'b1: 1 enables auto-repeat; 0 suppresses repeat_pulse entirely.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- btn  input  1  debounced button level, synchronous to clk.
- press_pulse  output  1  one-cycle pulse on a registered press.
- release_pulse  output  1  one-cycle pulse on release.
- hold_pulse  output  1  one-cycle pulse when a press reaches HOLD_CYCLES.
- repeat_pulse  output  1  one-cycle pulse every REPEAT_CYCLES while in long-press.
- held  output  1  level; high while button is considered down.
- press_count  output  8  number of registered presses, wraps 255->0.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset: all outputs 0, counter 0, state ARM. rst asserted mid-operation clears immediately; no release_pulse is produced.
- All outputs are registered, updated on posedge clk. Every pulse is high for exactly one cycle.
- Internal 16-bit cycle counter cnt.
- State ARM:
  - Waits for btn==0, then goes to IDLE.
  - A button already high when reset deasserts produces no press until it is seen low.
- State IDLE:
  - At an edge with btn==1: go to DOWN, cnt<=0, press_pulse<=1, held<=1, press_count<=press_count+1 (mod 256).
- State DOWN:
  - btn==0: go to IDLE, release_pulse<=1, held<=0, cnt<=0.
  - Else if cnt==HOLD_CYCLES-1: go to LONG, hold_pulse<=1, cnt<=0.
  - Else cnt<=cnt+1.
- State LONG:
  - btn==0: go to IDLE, release_pulse<=1, held<=0, cnt<=0.
  - Else if REPEAT_EN and cnt==REPEAT_CYCLES-1: repeat_pulse<=1, cnt<=0.
  - Else if REPEAT_EN: cnt<=cnt+1.
  - Else cnt holds at 0.
- Latency: press_pulse is visible in the cycle after the first edge sampling btn==1.
- hold_pulse follows press_pulse by exactly HOLD_CYCLES cycles.
- Successive repeat_pulse events are REPEAT_CYCLES apart; the first comes REPEAT_CYCLES after hold_pulse.
- Priority: release wins over hold/repeat on the same edge, so a release on the expiry edge produces release_pulse only.
- At most one pulse output is high in any cycle.
- btn high for exactly one sampled edge gives press_pulse, then release_pulse on the next cycle; no hold.
- Unused encoding: go to ARM with all pulses 0.
- press_count increments only on press_pulse and never on reset deassertion.

Test Plan:
- Reset mid-press: HOLD=8, btn high 3 cycles, pulse rst -> all outputs 0, no release_pulse. Hold btn high after reset -> no press_pulse until btn goes low then high again.
- Short press: HOLD=8, btn high 5 cycles -> press_pulse 1 cycle, held high 5 cycles, release_pulse once, no hold_pulse, press_count=1.
- Long press with repeat: HOLD=8, REPEAT=4, btn high 25 cycles:
  - hold_pulse 8 cycles after press_pulse;
  - repeat_pulse at +12, +16, +20, +24;
  - then release_pulse.
- Release on expiry edge: btn falls on the edge cnt hits HOLD_CYCLES-1 -> release_pulse only, no hold_pulse.
- REPEAT_EN=0: btn high 40 cycles, HOLD=8 -> exactly one hold_pulse, zero repeat_pulse, one release_pulse.
- Wrap: 257 short presses -> press_count reads 1. One-cycle btn glitch -> press_pulse then release_pulse in consecutive cycles.
